// File: rtl/spike_rate_classifier.sv
// rtl/spike_rate_classifier.sv - windowed per-neuron spike counter with argmax readout
module spike_rate_classifier #(
   parameter int N     = 8,
   parameter int IDXW  = 3,
   parameter int CW    = 6,
   parameter int WIN_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic [WIN_W-1:0] window_len,
   input  logic [N-1:0]     spikes_in,
   input  logic             result_ready,
   output logic             result_valid,
   output logic [IDXW-1:0]  winner_idx,
   output logic [CW-1:0]    winner_count,
   output logic             tie,
   output logic             no_spike,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_SCAN  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   localparam logic [CW-1:0]   CNT_MAX  = '1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q [N];
   logic [CW-1:0]     cnt_d [N];
   logic [WIN_W-1:0]  win_q, win_d;
   logic [IDXW-1:0]   scan_idx_q, scan_idx_d;
   logic [CW-1:0]     max_val_q, max_val_d;
   logic [IDXW-1:0]   max_idx_q, max_idx_d;
   logic              tie_q, tie_d;

   logic [WIN_W-1:0]  len_eff;
   logic [WIN_W:0]    win_inc;
   logic [CW-1:0]     cur_cnt;

   // A programmed length of 0 is treated as a one-sample window.
   assign len_eff = (window_len == '0) ? {{(WIN_W-1){1'b0}}, 1'b1} : window_len;
   assign win_inc = {1'b0, win_q} + {{WIN_W{1'b0}}, 1'b1};
   assign cur_cnt = cnt_q[scan_idx_q];

   // Next-state logic: counting, sequential argmax scan, result hold and handshake.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      win_d      = win_q;
      scan_idx_d = scan_idx_q;
      max_val_d  = max_val_q;
      max_idx_d  = max_idx_q;
      tie_d      = tie_q;

      case (state_q)
         S_IDLE, S_COUNT: begin
            if (enable) begin
               for (int i = 0; i < N; i++) begin
                  if (spikes_in[i] && (cnt_q[i] != CNT_MAX)) begin
                     cnt_d[i] = cnt_q[i] + 1'b1;
                  end
               end
               win_d = win_inc[WIN_W-1:0];
               // >= rather than == so a window shortened below the
               // current sample count closes on this edge.
               if (win_inc >= {1'b0, len_eff}) begin
                  state_d    = S_SCAN;
                  scan_idx_d = '0;
                  max_val_d  = '0;
                  max_idx_d  = '0;
                  tie_d      = 1'b0;
               end else begin
                  state_d = S_COUNT;
               end
            end
         end

         S_SCAN: begin
            if (enable) begin
               // Strict > keeps the lowest index on equal counts.
               if (cur_cnt > max_val_q) begin
                  max_val_d = cur_cnt;
                  max_idx_d = scan_idx_q;
                  tie_d     = 1'b0;
               end else if ((cur_cnt == max_val_q) && (max_val_q != '0)) begin
                  tie_d = 1'b1;
               end
               if (scan_idx_q == LAST_IDX) begin
                  state_d = S_OUT;
               end else begin
                  scan_idx_d = scan_idx_q + 1'b1;
               end
            end
         end

         S_OUT: begin
            if (result_ready) begin
               for (int i = 0; i < N; i++) begin
                  cnt_d[i] = '0;
               end
               win_d      = '0;
               scan_idx_d = '0;
               max_val_d  = '0;
               max_idx_d  = '0;
               tie_d      = 1'b0;
               state_d    = enable ? S_COUNT : S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Synchronous clear overrides everything, including a same-edge transfer.
      if (clear) begin
         for (int i = 0; i < N; i++) begin
            cnt_d[i] = '0;
         end
         win_d      = '0;
         scan_idx_d = '0;
         max_val_d  = '0;
         max_idx_d  = '0;
         tie_d      = 1'b0;
         state_d    = S_IDLE;
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
         end
         win_q      <= '0;
         scan_idx_q <= '0;
         max_val_q  <= '0;
         max_idx_q  <= '0;
         tie_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         for (int i = 0; i < N; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         win_q      <= win_d;
         scan_idx_q <= scan_idx_d;
         max_val_q  <= max_val_d;
         max_idx_q  <= max_idx_d;
         tie_q      <= tie_d;
      end
   end

   // Result fields are only presented while the result is offered.
   assign result_valid = (state_q == S_OUT);
   assign winner_idx   = result_valid ? max_idx_q : '0;
   assign winner_count = result_valid ? max_val_q : '0;
   assign tie          = result_valid & tie_q;
   assign no_spike     = result_valid & (max_val_q == '0);
   assign busy         = (state_q == S_SCAN) || (state_q == S_OUT);

endmodule

// File: tb/tb_spike_rate_classifier.sv
// tb/tb_spike_rate_classifier.sv - directed table-driven bench for spike_rate_classifier
module tb_spike_rate_classifier;

   localparam int N = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       clear;
   logic [7:0] window_len;
   logic [7:0] spikes_in;
   logic       result_ready;
   logic       result_valid;
   logic [2:0] winner_idx;
   logic [5:0] winner_count;
   logic       tie;
   logic       no_spike;
   logic       busy;

   int total = 0;
   int bad   = 0;

   spike_rate_classifier dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .clear        (clear),
      .window_len   (window_len),
      .spikes_in    (spikes_in),
      .result_ready (result_ready),
      .result_valid (result_valid),
      .winner_idx   (winner_idx),
      .winner_count (winner_count),
      .tie          (tie),
      .no_spike     (no_spike),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]      wl;
      logic [3:0][7:0] spk;
      logic [7:0]      fill;
      logic [2:0]      e_idx;
      logic [5:0]      e_cnt;
      logic            e_tie;
      logic            e_ns;
   } vec_t;

   vec_t vecs [8];

   function automatic vec_t mk(input logic [7:0] wl, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3, input logic [7:0] fill,
                               input logic [2:0] e_idx, input logic [5:0] e_cnt,
                               input logic e_tie, input logic e_ns);
      vec_t v;
      v.wl    = wl;
      v.spk   = {s3, s2, s1, s0};
      v.fill  = fill;
      v.e_idx = e_idx;
      v.e_cnt = e_cnt;
      v.e_tie = e_tie;
      v.e_ns  = e_ns;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [2:0] e_idx, input logic [5:0] e_cnt,
                            input logic e_tie, input logic e_ns);
      check({tag, " valid"}, 32'(result_valid), 32'd1);
      check({tag, " idx"},   32'(winner_idx),   32'(e_idx));
      check({tag, " count"}, 32'(winner_count), 32'(e_cnt));
      check({tag, " tie"},   32'(tie),          32'(e_tie));
      check({tag, " nospk"}, 32'(no_spike),     32'(e_ns));
      check({tag, " busy"},  32'(busy),         32'd1);
   endtask

   // Runs one window from IDLE with no stalls, checks latency and result, then hands off.
   task automatic run_vec(input string tag, input vec_t v);
      int  len;
      int  e;
      bit  got;
      len = (v.wl == 8'd0) ? 1 : int'(v.wl);
      window_len   = v.wl;
      enable       = 1'b1;
      result_ready = 1'b0;
      e   = 0;
      got = 0;
      while (!got && e < len + N + 10) begin
         if (e < len) spikes_in = (e < 4) ? v.spk[e] : v.fill;
         else         spikes_in = 8'hFF;
         step();
         e++;
         if (result_valid) got = 1;
      end
      check({tag, " latency"}, 32'(e), 32'(len + N));
      check_out(tag, v.e_idx, v.e_cnt, v.e_tie, v.e_ns);
      result_ready = 1'b1;
      enable       = 1'b0;
      spikes_in    = 8'hFF;
      step();
      check({tag, " valid after xfer"}, 32'(result_valid), 32'd0);
      check({tag, " busy after xfer"},  32'(busy),         32'd0);
      result_ready = 1'b0;
   endtask

   initial begin
      int  e;
      bit  got;

      vecs[0] = mk(8'd4,   8'h01, 8'h03, 8'h02, 8'h02, 8'h00, 3'd1, 6'd3,  1'b0, 1'b0);
      vecs[1] = mk(8'd2,   8'h05, 8'h05, 8'h00, 8'h00, 8'h00, 3'd0, 6'd2,  1'b1, 1'b0);
      vecs[2] = mk(8'd2,   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0, 6'd0,  1'b0, 1'b1);
      vecs[3] = mk(8'd100, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 3'd7, 6'd63, 1'b0, 1'b0);
      vecs[4] = mk(8'd0,   8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 3'd6, 6'd1,  1'b0, 1'b0);
      vecs[5] = mk(8'd3,   8'hFF, 8'h0F, 8'h01, 8'h00, 8'h00, 3'd0, 6'd3,  1'b0, 1'b0);
      vecs[6] = mk(8'd3,   8'h81, 8'h80, 8'h01, 8'h00, 8'h00, 3'd0, 6'd2,  1'b1, 1'b0);
      vecs[7] = mk(8'd2,   8'h10, 8'h18, 8'h00, 8'h00, 8'h00, 3'd4, 6'd2,  1'b0, 1'b0);

      reset        = 1'b0;
      enable       = 1'b0;
      clear        = 1'b0;
      window_len   = 8'd4;
      spikes_in    = 8'h00;
      result_ready = 1'b0;
      #12;
      check("reset valid", 32'(result_valid), 32'd0);
      check("reset idx",   32'(winner_idx),   32'd0);
      check("reset count", 32'(winner_count), 32'd0);
      check("reset tie",   32'(tie),          32'd0);
      check("reset nospk", 32'(no_spike),     32'd0);
      check("reset busy",  32'(busy),         32'd0);
      reset = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         run_vec($sformatf("v%0d", i), vecs[i]);
      end

      // Stalls: 5 disabled edges mid-COUNT and 2 mid-SCAN add exactly 7 edges.
      window_len = 8'd3;
      e   = 0;
      got = 0;
      while (!got && e < 30) begin
         e++;
         enable = !((e >= 3 && e <= 7) || (e >= 11 && e <= 12));
         spikes_in = (e == 1) ? 8'h01 : (e == 2) ? 8'h03 : (e == 8) ? 8'h02 : 8'hFF;
         step();
         if (result_valid) got = 1;
      end
      check("stall latency", 32'(e), 32'd18);
      check_out("stall", 3'd0, 6'd2, 1'b1, 1'b0);

      // Backpressure: result held with ready low while spikes and enable toggle.
      for (int i = 0; i < 10; i++) begin
         spikes_in = 8'($urandom);
         enable    = i[0];
         step();
         check($sformatf("hold%0d valid", i), 32'(result_valid), 32'd1);
         check($sformatf("hold%0d idx", i),   32'(winner_idx),   32'd0);
         check($sformatf("hold%0d count", i), 32'(winner_count), 32'd2);
         check($sformatf("hold%0d tie", i),   32'(tie),          32'd1);
      end
      result_ready = 1'b1;
      enable       = 1'b1;
      spikes_in    = 8'hFF;
      step();
      result_ready = 1'b0;
      check("xfer valid drop", 32'(result_valid), 32'd0);
      check("xfer busy drop",  32'(busy),         32'd0);
      window_len = 8'd1;
      e   = 0;
      got = 0;
      while (!got && e < 30) begin
         spikes_in = (e == 0) ? 8'h04 : 8'hFF;
         step();
         e++;
         if (result_valid) got = 1;
      end
      check("b2b latency", 32'(e), 32'd9);
      check_out("b2b", 3'd2, 6'd1, 1'b0, 1'b0);
      result_ready = 1'b1;
      enable       = 1'b0;
      step();
      result_ready = 1'b0;

      // Clear mid-COUNT discards the partial window.
      window_len = 8'd4;
      enable     = 1'b1;
      spikes_in  = 8'h01;
      step();
      step();
      clear = 1'b1;
      step();
      clear  = 1'b0;
      enable = 1'b0;
      check("clr count busy", 32'(busy), 32'd0);
      run_vec("after clr", mk(8'd2, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 3'd1, 6'd2, 1'b0, 1'b0));

      // Clear on the same edge as a handshake wins.
      run_to_out_and_clear();

      // Asynchronous reset mid-SCAN.
      window_len = 8'd2;
      enable     = 1'b1;
      spikes_in  = 8'h01;
      step();
      step();
      spikes_in = 8'h00;
      step();
      step();
      step();
      check("scan busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("areset scan busy",  32'(busy),         32'd0);
      check("areset scan valid", 32'(result_valid), 32'd0);
      #2;
      reset = 1'b1;
      enable = 1'b0;
      step();

      // Asynchronous reset while a result is offered.
      window_len = 8'd1;
      enable     = 1'b1;
      spikes_in  = 8'h08;
      e   = 0;
      got = 0;
      while (!got && e < 30) begin
         step();
         spikes_in = 8'h00;
         e++;
         if (result_valid) got = 1;
      end
      check_out("pre-areset", 3'd3, 6'd1, 1'b0, 1'b0);
      #2;
      reset = 1'b0;
      #1;
      check("areset out valid", 32'(result_valid), 32'd0);
      check("areset out idx",   32'(winner_idx),   32'd0);
      check("areset out count", 32'(winner_count), 32'd0);
      check("areset out busy",  32'(busy),         32'd0);
      #2;
      reset  = 1'b1;
      enable = 1'b0;
      step();
      run_vec("post-areset", mk(8'd1, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 3'd5, 6'd1, 1'b0, 1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   task automatic run_to_out_and_clear();
      int e;
      bit got;
      window_len   = 8'd2;
      enable       = 1'b1;
      result_ready = 1'b0;
      e   = 0;
      got = 0;
      while (!got && e < 30) begin
         spikes_in = (e < 2) ? 8'h20 : 8'h00;
         step();
         e++;
         if (result_valid) got = 1;
      end
      check_out("pre-clr", 3'd5, 6'd2, 1'b0, 1'b0);
      result_ready = 1'b1;
      clear        = 1'b1;
      spikes_in    = 8'hFF;
      step();
      clear        = 1'b0;
      result_ready = 1'b0;
      enable       = 1'b0;
      check("clr+xfer valid", 32'(result_valid), 32'd0);
      check("clr+xfer busy",  32'(busy),         32'd0);
      step();
      check("clr+xfer idle", 32'(result_valid), 32'd0);
      run_vec("after clr+xfer", mk(8'd1, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 3'd1, 6'd1, 1'b0, 1'b0));
   endtask

endmodule
